// File: rtl/hilo_muldiv_sequencer.sv
// Multi-cycle multiply/divide engine owning the HI/LO registers; one shift-add or
// restoring-divide iteration per cycle, followed by a sign-fixup cycle.
//
//  state  | meaning
//  IDLE   | engine free; serves moves, accepts Start
//  CALC   | one iteration per cycle, counter 0..DATA_WIDTH-1
//  SIGN   | sign fixup and HI/LO write
module hilo_muldiv_sequencer #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_start,
    input  logic [1:0]            i_op,
    input  logic [DATA_WIDTH-1:0] i_operand_a,
    input  logic [DATA_WIDTH-1:0] i_operand_b,
    input  logic                  i_mfhi,
    input  logic                  i_mflo,
    input  logic                  i_mthi,
    input  logic                  i_mtlo,
    input  logic [DATA_WIDTH-1:0] i_write_data,
    input  logic                  i_flush,
    output logic                  o_busy,
    output logic                  o_stall,
    output logic [DATA_WIDTH-1:0] o_hi,
    output logic [DATA_WIDTH-1:0] o_lo,
    output logic [DATA_WIDTH-1:0] o_read_data,
    output logic                  o_div_zero
);
    localparam int W     = DATA_WIDTH;
    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_SIGN = 2'd2;

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2*W-1:0]   r_acc;
    logic [W-1:0]     r_opb;
    logic             r_is_div;
    logic             r_neg_q;
    logic             r_neg_r;
    logic [W-1:0]     r_hi;
    logic [W-1:0]     r_lo;
    logic             r_div_zero;

    logic             w_busy;
    logic             w_signed;
    logic             w_is_div;
    logic             w_neg_a;
    logic             w_neg_b;
    logic [W-1:0]     w_mag_a;
    logic [W-1:0]     w_mag_b;
    logic             w_div_by_zero;
    logic             w_accept;
    logic [W:0]       w_mul_sum;
    logic [2*W-1:0]   w_mul_next;
    logic [W:0]       w_sh_hi;
    logic [W-1:0]     w_sh_lo;
    logic [W:0]       w_diff;
    logic [2*W-1:0]   w_div_next;
    logic [2*W-1:0]   w_prod_fix;
    logic [W-1:0]     w_quo_fix;
    logic [W-1:0]     w_rem_fix;

    assign w_busy        = (r_state != S_IDLE);
    assign w_signed      = ~i_op[0];
    assign w_is_div      = i_op[1];
    assign w_neg_a       = w_signed & i_operand_a[W-1];
    assign w_neg_b       = w_signed & i_operand_b[W-1];
    assign w_mag_a       = w_neg_a ? -i_operand_a : i_operand_a;
    assign w_mag_b       = w_neg_b ? -i_operand_b : i_operand_b;
    assign w_div_by_zero = w_is_div & (i_operand_b == '0);
    assign w_accept      = (r_state == S_IDLE) & i_start & ~i_flush;

    // Multiply: add multiplicand into the upper half when the LSB is set, then shift right.
    assign w_mul_sum  = {1'b0, r_acc[2*W-1:W]} + {1'b0, r_opb & {W{r_acc[0]}}};
    assign w_mul_next = {w_mul_sum, r_acc[W-1:1]};

    // Divide: shift {rem, dividend} left, subtract divisor; quotient bits enter at the LSB.
    assign w_sh_hi    = r_acc[2*W-1:W-1];
    assign w_sh_lo    = {r_acc[W-2:0], 1'b0};
    assign w_diff     = w_sh_hi - {1'b0, r_opb};
    assign w_div_next = w_diff[W] ? {w_sh_hi[W-1:0], w_sh_lo}
                                  : {w_diff[W-1:0], w_sh_lo[W-1:1], 1'b1};

    assign w_prod_fix = r_neg_q ? -r_acc : r_acc;
    assign w_quo_fix  = r_neg_q ? -r_acc[W-1:0] : r_acc[W-1:0];
    assign w_rem_fix  = r_neg_r ? -r_acc[2*W-1:W] : r_acc[2*W-1:W];

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_acc      <= '0;
            r_opb      <= '0;
            r_is_div   <= 1'b0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_div_zero <= 1'b0;
        end else begin
            r_div_zero <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (w_div_by_zero) begin
                            r_div_zero <= 1'b1;
                        end else begin
                            r_is_div <= w_is_div;
                            r_neg_q  <= w_neg_a ^ w_neg_b;
                            r_neg_r  <= w_neg_a;
                            r_cnt    <= '0;
                            r_state  <= S_CALC;
                            if (w_is_div) begin
                                r_acc <= {{W{1'b0}}, w_mag_a};
                                r_opb <= w_mag_b;
                            end else begin
                                r_acc <= {{W{1'b0}}, w_mag_b};
                                r_opb <= w_mag_a;
                            end
                        end
                    end else if (!i_start) begin
                        if (i_mthi) r_hi <= i_write_data;
                        if (i_mtlo) r_lo <= i_write_data;
                    end
                end
                S_CALC: begin
                    if (i_flush) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_acc <= r_is_div ? w_div_next : w_mul_next;
                        if (r_cnt == CNT_LAST) begin
                            r_cnt   <= '0;
                            r_state <= S_SIGN;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                S_SIGN: begin
                    if (!i_flush) begin
                        if (r_is_div) begin
                            r_lo <= w_quo_fix;
                            r_hi <= w_rem_fix;
                        end else begin
                            r_hi <= w_prod_fix[2*W-1:W];
                            r_lo <= w_prod_fix[W-1:0];
                        end
                    end
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_busy      = w_busy;
    assign o_stall     = w_busy & (i_start | i_mfhi | i_mflo | i_mthi | i_mtlo);
    assign o_hi        = r_hi;
    assign o_lo        = r_lo;
    assign o_read_data = i_mfhi ? r_hi : (i_mflo ? r_lo : '0);
    assign o_div_zero  = r_div_zero;
endmodule

// File: tb/tb_hilo_muldiv_sequencer.sv
// Directed bench: stimulus pushes expected {HI,LO} into a queue; a monitor pops and
// compares on every Busy falling edge.
module tb_hilo_muldiv_sequencer;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        start, mfhi, mflo, mthi, mtlo, flush;
    logic [1:0]  op;
    logic [31:0] opa, opb, wdata;
    logic        busy, stall, div_zero;
    logic [31:0] hi, lo, rdata;

    int n_tests = 0;
    int n_fail  = 0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    hilo_muldiv_sequencer #(.DATA_WIDTH(32)) dut (
        .i_clk(clk), .i_reset_n(reset_n), .i_start(start), .i_op(op),
        .i_operand_a(opa), .i_operand_b(opb), .i_mfhi(mfhi), .i_mflo(mflo),
        .i_mthi(mthi), .i_mtlo(mtlo), .i_write_data(wdata), .i_flush(flush),
        .o_busy(busy), .o_stall(stall), .o_hi(hi), .o_lo(lo),
        .o_read_data(rdata), .o_div_zero(div_zero)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every completed/aborted operation must leave the queued HI/LO.
    logic prev_busy = 1'b0;
    always @(negedge clk) begin
        if (prev_busy === 1'b1 && busy === 1'b0) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_busy_fall", 32'd1, 32'd0);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                chk("sb_hi", hi, e[63:32]);
                chk("sb_lo", lo, e[31:0]);
            end
        end
        prev_busy = busy;
    end

    task automatic issue(input string name, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
        int n;
        op = o; opa = a; opb = b; start = 1'b1;
        exp_q.push_back({eh, el});
        tick();
        start = 1'b0;
        n = 0;
        while (busy && n < 100) begin
            n++;
            tick();
        end
        chk({name, "_busy_cycles"}, n, 33);
    endtask

    initial begin
        int n;
        int stall_bad;
        reset_n = 1'b0; start = 0; mfhi = 0; mflo = 0; mthi = 0; mtlo = 0; flush = 0;
        op = 0; opa = 0; opb = 0; wdata = 0;
        tick(); tick();
        reset_n = 1'b1;
        tick();
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        chk("rst_busy", busy, 0);
        chk("rst_stall", stall, 0);
        mfhi = 1'b1; #1;
        chk("rst_mfhi", rdata, 0);
        mfhi = 1'b0;

        issue("mult_neg", 2'b00, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA);
        issue("multu",    2'b01, 32'hFFFFFFFE, 32'd3, 32'h00000002, 32'hFFFFFFFA);
        issue("div_neg",  2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
        issue("divu",     2'b11, 32'd7,        32'd2, 32'd1,        32'd3);
        issue("div_ovf",  2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000);
        issue("mult_min", 2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0);
        issue("divu_big", 2'b11, 32'hFFFFFFFF, 32'h10, 32'hF, 32'h0FFFFFFF);

        // Moves, then divide by zero leaves HI/LO alone.
        mthi = 1'b1; wdata = 32'h11; tick(); mthi = 1'b0;
        mtlo = 1'b1; wdata = 32'h22; tick(); mtlo = 1'b0;
        chk("mthi", hi, 32'h11);
        chk("mtlo", lo, 32'h22);
        op = 2'b11; opa = 32'd5; opb = 32'd0; start = 1'b1;
        tick();
        start = 1'b0;
        chk("dz_pulse", div_zero, 1);
        chk("dz_busy", busy, 0);
        tick();
        chk("dz_pulse_end", div_zero, 0);
        chk("dz_hi", hi, 32'h11);
        chk("dz_lo", lo, 32'h22);

        // Flush in IDLE blocks the start.
        op = 2'b01; opa = 32'd2; opb = 32'd2; start = 1'b1; flush = 1'b1;
        tick();
        start = 1'b0; flush = 1'b0;
        chk("idle_flush_busy", busy, 0);

        // mflo held from cycle 5 of a mult stalls until Busy drops.
        op = 2'b00; opa = 32'd5; opb = 32'd7; start = 1'b1;
        exp_q.push_back({32'd0, 32'd35});
        tick();
        start = 1'b0;
        tick(); tick(); tick(); tick();
        mflo = 1'b1; #1;
        n = 5; stall_bad = 0;
        while (busy && n < 100) begin
            if (stall !== 1'b1) stall_bad++;
            tick();
            n++;
        end
        chk("stall_held", stall_bad, 0);
        chk("stall_release_cycle", n, 34);
        chk("stall_low", stall, 0);
        chk("mflo_new_lo", rdata, 32'd35);
        mflo = 1'b0;

        // Flush on cycle 10 of a div keeps previous HI/LO.
        op = 2'b10; opa = 32'd100; opb = 32'd7; start = 1'b1;
        exp_q.push_back({32'd0, 32'd35});
        tick();
        start = 1'b0;
        for (int i = 1; i < 10; i++) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_busy", busy, 0);
        mthi = 1'b1; wdata = 32'hDEADBEEF;
        tick();
        mthi = 1'b0;
        chk("post_flush_mthi", hi, 32'hDEADBEEF);
        chk("post_flush_lo", lo, 32'd35);

        // Reset mid-CALC.
        op = 2'b01; opa = 32'd3; opb = 32'd4; start = 1'b1;
        exp_q.push_back({32'd0, 32'd0});
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        reset_n = 1'b0;
        tick();
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_hi", hi, 0);
        chk("rst_mid_lo", lo, 0);
        reset_n = 1'b1;
        tick(); tick();

        chk("sb_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
